move_sequencer: RTL and testbench

//  Buffers solver move codes in a FIFO and plays them one at a time onto the shared stepper bus.
//  The bus is one STEP line, one DIR line and six per-face ENABLE lines.

---
 rtl/move_sequencer_if.sv | 31 +++
 rtl/move_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// Producer/driver-side signal bundle for move_sequencer: queue push, run control and stepper bus.
// master = move-queue producer / pin consumer, slave = the sequencer itself.
interface move_sequencer_if;
   logic       i_push;
   logic [3:0] i_push_move;
   logic       i_start;
   logic       i_abort;
   logic       i_ls_ready;
   logic       o_full;
   logic       o_empty;
   logic [5:0] o_en;
   logic       o_step;
   logic       o_dir;
   logic       o_busy;
   logic [3:0] o_cur_move;
   logic [7:0] o_moves_done;
   logic       o_done;
   logic       o_err;

   modport master (
      output i_push, i_push_move, i_start, i_abort, i_ls_ready,
      input  o_full, o_empty, o_en, o_step, o_dir, o_busy, o_cur_move,
             o_moves_done, o_done, o_err
   );

   modport slave (
      input  i_push, i_push_move, i_start, i_abort, i_ls_ready,
      output o_full, o_empty, o_en, o_step, o_dir, o_busy, o_cur_move,
             o_moves_done, o_done, o_err
   );
endinterface

// File: rtl/move_sequencer.sv
// Move FIFO plus sequencer that plays queued codes as quarter turns on the shared stepper bus.
// All outputs registered; pushes to a full FIFO are dropped, i_ls_ready gates each move start.
module move_sequencer_fifo #(
   parameter int DEPTH = 32,
   parameter int W     = 4
) (
   input  logic         i_clk_12m,
   input  logic         i_rst_n,
   input  logic         wr_vld_i,
   input  logic [W-1:0] wr_dat_i,
   input  logic         rd_i,
   input  logic         flush_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] rd_dat_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, empty_q;
   logic          wr_ok, rd_ok;

   // Full is checked against the registered flag, so a same-cycle pop never rescues a push.
   assign wr_ok    = wr_vld_i & ~full_q & ~flush_i;
   assign rd_ok    = rd_i & ~empty_q & ~flush_i;
   assign rd_dat_o = mem_q[rd_ptr_q];
   assign full_o   = full_q;
   assign empty_o  = empty_q;

   always_comb begin
      cnt_d = cnt_q;
      if (flush_i) begin
         cnt_d = '0;
      end else begin
         case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge i_clk_12m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == CNT_FULL);
         empty_q <= (cnt_d == '0);
      end
   end

   always_ff @(posedge i_clk_12m) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_dat_i;
   end
endmodule

module move_sequencer #(
   parameter int DEPTH         = 32,
   parameter int STEPS_PER_QTR = 50,
   parameter int STEP_HALF     = 3000,
   parameter int SETTLE        = 12000,
   parameter int HOLD          = 12000
) (
   input  logic             i_clk_12m,
   input  logic             i_rst_n,
   move_sequencer_if.slave  bus
);
   localparam int TMAX = (SETTLE > HOLD) ? ((SETTLE > STEP_HALF) ? SETTLE : STEP_HALF)
                                         : ((HOLD > STEP_HALF) ? HOLD : STEP_HALF);
   localparam int TW = $clog2(TMAX + 1);
   localparam int SW = $clog2(STEPS_PER_QTR + 1);
   localparam logic [TW-1:0] T_ONE       = TW'(1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
   localparam logic [TW-1:0] HALF_LAST   = TW'(STEP_HALF - 1);
   localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD - 1);
   localparam logic [SW-1:0] S_ONE       = SW'(1);
   localparam logic [SW-1:0] STEPS_LAST  = SW'(STEPS_PER_QTR - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT_LS, S_SETUP, S_STEP_HI, S_STEP_LO, S_HOLD, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [SW-1:0] step_cnt_q, step_cnt_d;
   logic [3:0]    cur_move_q, cur_move_d;
   logic [5:0]    en_q, en_d;
   logic          dir_q, dir_d;
   logic          step_q, step_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [7:0]    moves_done_q, moves_done_d;

   logic          fifo_full, fifo_empty, pop;
   logic [3:0]    head;
   logic          head_rsvd, phase_last, active_d;
   logic [3:0]    face_idx;

   move_sequencer_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
      .i_clk_12m (i_clk_12m),
      .i_rst_n   (i_rst_n),
      .wr_vld_i  (bus.i_push),
      .wr_dat_i  (bus.i_push_move),
      .rd_i      (pop),
      .flush_i   (bus.i_abort),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .rd_dat_o  (head)
   );

   assign head_rsvd = (head >= 4'd13);
   assign face_idx  = (cur_move_q <= 4'd6) ? (cur_move_q - 4'd1) : (cur_move_q - 4'd7);

   always_comb begin
      phase_last = 1'b0;
      case (state_q)
         S_SETUP:              phase_last = (timer_q == SETTLE_LAST);
         S_STEP_HI, S_STEP_LO: phase_last = (timer_q == HALF_LAST);
         S_HOLD:               phase_last = (timer_q == HOLD_LAST);
         default:              phase_last = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk_12m or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.i_abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    if (bus.i_start) state_d = S_FETCH;
            S_FETCH: begin
               if (fifo_empty || head == 4'd0) state_d = S_DONE;
               else if (!head_rsvd)            state_d = S_WAIT_LS;
            end
            S_WAIT_LS: if (bus.i_ls_ready) state_d = S_SETUP;
            S_SETUP:   if (phase_last) state_d = S_STEP_HI;
            S_STEP_HI: if (phase_last) state_d = S_STEP_LO;
            S_STEP_LO: if (phase_last) state_d = (step_cnt_q == STEPS_LAST) ? S_HOLD : S_STEP_HI;
            S_HOLD:    if (phase_last) state_d = S_FETCH;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // Bus outputs follow the next state so they change on the same edge as the state.
   always_comb begin
      pop          = 1'b0;
      timer_d      = '0;
      step_cnt_d   = step_cnt_q;
      cur_move_d   = cur_move_q;
      dir_d        = dir_q;
      moves_done_d = moves_done_q;
      err_d        = 1'b0;
      active_d     = (state_d == S_SETUP) || (state_d == S_STEP_HI) ||
                     (state_d == S_STEP_LO) || (state_d == S_HOLD);
      en_d         = active_d ? (6'b000001 << face_idx) : 6'b000000;
      step_d       = (state_d == S_STEP_HI);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);

      if (state_d == state_q && active_d) timer_d = timer_q + T_ONE;

      if (bus.i_abort) begin
         cur_move_d = 4'd0;
      end else begin
         case (state_q)
            S_IDLE: if (bus.i_start) moves_done_d = 8'd0;
            S_FETCH: begin
               pop = ~fifo_empty;
               if (!fifo_empty && head_rsvd) err_d = 1'b1;
               if (!fifo_empty && head != 4'd0 && !head_rsvd) cur_move_d = head;
            end
            S_WAIT_LS: begin
               step_cnt_d = '0;
               // Direction only moves while every enable is still low.
               if (bus.i_ls_ready) dir_d = (cur_move_q <= 4'd6);
            end
            S_STEP_LO: if (phase_last) step_cnt_d = step_cnt_q + S_ONE;
            S_HOLD: begin
               if (phase_last) begin
                  cur_move_d = 4'd0;
                  if (moves_done_q != 8'd255) moves_done_d = moves_done_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk_12m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         timer_q      <= '0;
         step_cnt_q   <= '0;
         cur_move_q   <= 4'd0;
         en_q         <= 6'd0;
         dir_q        <= 1'b0;
         step_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         moves_done_q <= 8'd0;
      end else begin
         timer_q      <= timer_d;
         step_cnt_q   <= step_cnt_d;
         cur_move_q   <= cur_move_d;
         en_q         <= en_d;
         dir_q        <= dir_d;
         step_q       <= step_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         moves_done_q <= moves_done_d;
      end
   end

   assign bus.o_full       = fifo_full;
   assign bus.o_empty      = fifo_empty;
   assign bus.o_en         = en_q;
   assign bus.o_step       = step_q;
   assign bus.o_dir        = dir_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_cur_move   = cur_move_q;
   assign bus.o_moves_done = moves_done_q;
   assign bus.o_done       = done_q;
   assign bus.o_err        = err_q;
endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with short phase parameters (3 steps, half 2, settle 4, hold 4).
module tb_move_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   move_sequencer_if ifc();

   move_sequencer #(
      .DEPTH(32), .STEPS_PER_QTR(3), .STEP_HALF(2), .SETTLE(4), .HOLD(4)
   ) dut (
      .i_clk_12m (clk),
      .i_rst_n   (rst_n),
      .bus       (ifc)
   );

   int total = 0;
   int bad   = 0;

   // Bus monitor: records every enable window (face, direction, step count, length).
   int         n_mv = 0, n_done = 0, n_err = 0, dir_viol = 0, oh_viol = 0, step_noen = 0;
   int         cur_steps = 0, cur_len = 0;
   logic [5:0] en_hist [64];
   logic       dir_hist [64];
   int         steps_hist [64];
   int         len_hist [64];
   logic [5:0] prev_en = 6'd0;
   logic       prev_step = 1'b0, prev_dir = 1'b0;

   always @(negedge clk) begin
      if (ifc.o_en != 6'd0 && prev_en == 6'd0) begin
         en_hist[n_mv % 64]  = ifc.o_en;
         dir_hist[n_mv % 64] = ifc.o_dir;
         cur_steps = 0;
         cur_len   = 0;
      end
      if (ifc.o_en != 6'd0) begin
         cur_len++;
         if (ifc.o_step && !prev_step) cur_steps++;
         if (prev_en != 6'd0 && ifc.o_dir != prev_dir) dir_viol++;
         if (!$onehot(ifc.o_en)) oh_viol++;
      end else if (ifc.o_step) begin
         step_noen++;
      end
      if (ifc.o_en == 6'd0 && prev_en != 6'd0) begin
         steps_hist[n_mv % 64] = cur_steps;
         len_hist[n_mv % 64]   = cur_len;
         n_mv++;
      end
      if (ifc.o_done) n_done++;
      if (ifc.o_err)  n_err++;
      prev_en   = ifc.o_en;
      prev_step = ifc.o_step;
      prev_dir  = ifc.o_dir;
   end

   task automatic push_code(input logic [3:0] c);
      ifc.i_push = 1'b1;
      ifc.i_push_move = c;
      @(posedge clk); #1;
      ifc.i_push = 1'b0;
   endtask

   task automatic start_seq();
      ifc.i_start = 1'b1;
      @(posedge clk); #1;
      ifc.i_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (!ifc.o_busy) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      total++;
      if ({ifc.o_en, ifc.o_step, ifc.o_dir, ifc.o_cur_move, ifc.o_moves_done,
           ifc.o_done, ifc.o_err, ifc.o_busy} !== 23'd0) begin
         bad++;
         $display("FAIL reset_outs: got en=%b step=%b dir=%b cur=%0d md=%0d done=%b err=%b busy=%b want all 0",
                  ifc.o_en, ifc.o_step, ifc.o_dir, ifc.o_cur_move, ifc.o_moves_done,
                  ifc.o_done, ifc.o_err, ifc.o_busy);
      end
      total++;
      if ({ifc.o_empty, ifc.o_full} !== 2'b10) begin
         bad++;
         $display("FAIL reset_fifo: got empty=%b full=%b want empty=1 full=0", ifc.o_empty, ifc.o_full);
      end
   endtask

   task automatic test_basic();
      int b, d0;
      bit ok;
      b = n_mv; d0 = n_done;
      ifc.i_ls_ready = 1'b1;
      push_code(4'd1);
      push_code(4'd9);
      start_seq();
      wait_idle(200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL basic_timeout: busy stayed high, want idle"); end
      total++;
      if (n_mv - b !== 2) begin bad++; $display("FAIL basic_moves: got %0d want 2", n_mv - b); end
      total++;
      if ({en_hist[b % 64], dir_hist[b % 64]} !== 7'b000001_1) begin
         bad++; $display("FAIL basic_mv0: got en=%b dir=%b want en=000001 dir=1", en_hist[b % 64], dir_hist[b % 64]);
      end
      total++;
      if ({en_hist[(b+1) % 64], dir_hist[(b+1) % 64]} !== 7'b000100_0) begin
         bad++; $display("FAIL basic_mv1: got en=%b dir=%b want en=000100 dir=0", en_hist[(b+1) % 64], dir_hist[(b+1) % 64]);
      end
      total++;
      if (steps_hist[b % 64] !== 3 || steps_hist[(b+1) % 64] !== 3) begin
         bad++; $display("FAIL basic_steps: got %0d,%0d want 3,3", steps_hist[b % 64], steps_hist[(b+1) % 64]);
      end
      total++;
      if (len_hist[b % 64] !== 20) begin
         bad++; $display("FAIL basic_len: got %0d want 20", len_hist[b % 64]);
      end
      total++;
      if (ifc.o_moves_done !== 8'd2) begin bad++; $display("FAIL basic_count: got %0d want 2", ifc.o_moves_done); end
      total++;
      if (n_done - d0 !== 1) begin bad++; $display("FAIL basic_done: got %0d want 1", n_done - d0); end
      total++;
      if (ifc.o_empty !== 1'b1 || ifc.o_cur_move !== 4'd0) begin
         bad++; $display("FAIL basic_end: got empty=%b cur=%0d want empty=1 cur=0", ifc.o_empty, ifc.o_cur_move);
      end
   endtask

   task automatic test_full();
      int b, nbad;
      bit ok;
      logic [3:0] c;
      b = n_mv;
      for (int i = 0; i < 32; i++) begin
         c = 4'((i % 12) + 1);
         push_code(c);
      end
      total++;
      if ({ifc.o_full, ifc.o_empty} !== 2'b10) begin
         bad++; $display("FAIL full_flag: got full=%b empty=%b want full=1 empty=0", ifc.o_full, ifc.o_empty);
      end
      push_code(4'd5);
      start_seq();
      wait_idle(2000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL full_timeout: busy stayed high, want idle"); end
      total++;
      if (n_mv - b !== 32 || ifc.o_moves_done !== 8'd32) begin
         bad++; $display("FAIL full_moves: got mon=%0d count=%0d want 32", n_mv - b, ifc.o_moves_done);
      end
      total++;
      if ({en_hist[(b+31) % 64], dir_hist[(b+31) % 64]} !== 7'b000010_0) begin
         bad++; $display("FAIL full_last: got en=%b dir=%b want en=000010 dir=0", en_hist[(b+31) % 64], dir_hist[(b+31) % 64]);
      end
      nbad = 0;
      for (int k = b; k < b + 32; k++) if (steps_hist[k % 64] != 3) nbad++;
      total++;
      if (nbad !== 0) begin bad++; $display("FAIL full_steps: got %0d short moves want 0", nbad); end
   endtask

   task automatic test_err();
      int b, e0;
      bit ok;
      b = n_mv; e0 = n_err;
      push_code(4'd14);
      push_code(4'd3);
      start_seq();
      wait_idle(200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL err_timeout: busy stayed high, want idle"); end
      total++;
      if (n_err - e0 !== 1) begin bad++; $display("FAIL err_pulse: got %0d want 1", n_err - e0); end
      total++;
      if (n_mv - b !== 1 || {en_hist[b % 64], dir_hist[b % 64]} !== 7'b000100_1) begin
         bad++; $display("FAIL err_move: got n=%0d en=%b dir=%b want n=1 en=000100 dir=1", n_mv - b, en_hist[b % 64], dir_hist[b % 64]);
      end
      total++;
      if (ifc.o_moves_done !== 8'd1) begin bad++; $display("FAIL err_count: got %0d want 1", ifc.o_moves_done); end
   endtask

   task automatic test_end_code();
      int b, d0;
      bit ok;
      b = n_mv; d0 = n_done;
      push_code(4'd2);
      push_code(4'd0);
      push_code(4'd5);
      start_seq();
      wait_idle(200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL end_timeout: busy stayed high, want idle"); end
      total++;
      if (n_mv - b !== 1 || en_hist[b % 64] !== 6'b000010) begin
         bad++; $display("FAIL end_move: got n=%0d en=%b want n=1 en=000010", n_mv - b, en_hist[b % 64]);
      end
      total++;
      if (n_done - d0 !== 1 || ifc.o_empty !== 1'b0) begin
         bad++; $display("FAIL end_retain: got done=%0d empty=%b want done=1 empty=0", n_done - d0, ifc.o_empty);
      end
      start_seq();
      wait_idle(200, ok);
      total++;
      if (!ok || n_mv - b !== 2 || {en_hist[(b+1) % 64], dir_hist[(b+1) % 64]} !== 7'b010000_1) begin
         bad++; $display("FAIL end_resume: got ok=%b n=%0d en=%b dir=%b want ok=1 n=2 en=010000 dir=1",
                         ok, n_mv - b, en_hist[(b+1) % 64], dir_hist[(b+1) % 64]);
      end
      total++;
      if (ifc.o_empty !== 1'b1 || ifc.o_moves_done !== 8'd1) begin
         bad++; $display("FAIL end_after: got empty=%b count=%0d want empty=1 count=1", ifc.o_empty, ifc.o_moves_done);
      end
   endtask

   task automatic test_ls_wait();
      int moved;
      bit ok;
      ifc.i_ls_ready = 1'b0;
      push_code(4'd4);
      start_seq();
      moved = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (ifc.o_en != 6'd0 || ifc.o_step || !ifc.o_busy) moved++;
      end
      total++;
      if (moved !== 0) begin bad++; $display("FAIL ls_stall: got %0d active cycles want 0", moved); end
      ifc.i_ls_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({ifc.o_en, ifc.o_dir, ifc.o_step} !== 8'b001000_1_0) begin
         bad++; $display("FAIL ls_setup: got en=%b dir=%b step=%b want en=001000 dir=1 step=0", ifc.o_en, ifc.o_dir, ifc.o_step);
      end
      wait_idle(200, ok);
      total++;
      if (!ok || ifc.o_moves_done !== 8'd1) begin
         bad++; $display("FAIL ls_finish: got ok=%b count=%0d want ok=1 count=1", ok, ifc.o_moves_done);
      end
   endtask

   task automatic test_abort();
      int d0;
      bit seen;
      d0 = n_done;
      push_code(4'd1);
      push_code(4'd2);
      push_code(4'd3);
      start_seq();
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk); #1;
         if (ifc.o_step) seen = 1'b1;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL abort_nostep: got no step want step in move 1"); end
      ifc.i_abort = 1'b1;
      ifc.i_push = 1'b1;
      ifc.i_push_move = 4'd6;
      @(posedge clk); #1;
      ifc.i_abort = 1'b0;
      ifc.i_push = 1'b0;
      total++;
      if ({ifc.o_en, ifc.o_step, ifc.o_cur_move, ifc.o_busy} !== 12'd0) begin
         bad++; $display("FAIL abort_outs: got en=%b step=%b cur=%0d busy=%b want all 0",
                         ifc.o_en, ifc.o_step, ifc.o_cur_move, ifc.o_busy);
      end
      total++;
      if (ifc.o_empty !== 1'b1 || ifc.o_moves_done !== 8'd0) begin
         bad++; $display("FAIL abort_flush: got empty=%b count=%0d want empty=1 count=0", ifc.o_empty, ifc.o_moves_done);
      end
      repeat (30) @(posedge clk);
      #1;
      total++;
      if (n_done - d0 !== 0 || ifc.o_en !== 6'd0) begin
         bad++; $display("FAIL abort_quiet: got done=%0d en=%b want done=0 en=0", n_done - d0, ifc.o_en);
      end
   endtask

   task automatic test_async_reset();
      bit seen;
      push_code(4'd1);
      push_code(4'd2);
      start_seq();
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk); #1;
         if (ifc.o_step) seen = 1'b1;
      end
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (!seen || {ifc.o_en, ifc.o_step, ifc.o_dir, ifc.o_cur_move, ifc.o_busy} !== 13'd0) begin
         bad++; $display("FAIL arst_outs: got seen=%b en=%b step=%b dir=%b cur=%0d busy=%b want seen=1 rest 0",
                         seen, ifc.o_en, ifc.o_step, ifc.o_dir, ifc.o_cur_move, ifc.o_busy);
      end
      total++;
      if (ifc.o_empty !== 1'b1) begin bad++; $display("FAIL arst_fifo: got empty=%b want 1", ifc.o_empty); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      ifc.i_push = 1'b0;
      ifc.i_push_move = 4'd0;
      ifc.i_start = 1'b0;
      ifc.i_abort = 1'b0;
      ifc.i_ls_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_basic();
      test_full();
      test_err();
      test_end_code();
      test_ls_wait();
      test_abort();
      total++;
      if (dir_viol !== 0 || oh_viol !== 0 || step_noen !== 0) begin
         bad++; $display("FAIL bus_rules: got dirchg=%0d multi_en=%0d stray_step=%0d want 0", dir_viol, oh_viol, step_noen);
      end
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
